// File: rtl/grad_vector_collector.sv
// Collects a serial stream of IEEE-754 gradient elements into an indexed vector.
// It also tracks the largest-magnitude element and flags convergence when the pass completes.
module grad_vector_collector #(
  parameter int unsigned           NUM_ELEMENTS = 50,
  parameter int unsigned           DATA_WIDTH   = 64,
  parameter int unsigned           IDX_W        = 6,
  parameter logic [DATA_WIDTH-1:0] GRAD_TOL     = 64'h3EB0C6F7A0B5ED8D
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  grad_valid,
  input  logic [DATA_WIDTH-1:0]                 grad_data,
  input  logic                                  grad_flagover,
  output logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] grad_vec,
  output logic [IDX_W-1:0]                      grad_count,
  output logic                                  busy,
  output logic                                  done,
  output logic [DATA_WIDTH-1:0]                 max_abs,
  output logic [IDX_W-1:0]                      max_idx,
  output logic                                  converged,
  output logic                                  err_short,
  output logic                                  err_overflow,
  output logic                                  nan_seen
);

  localparam int unsigned MAG_W  = DATA_WIDTH - 1;
  localparam int unsigned EXP_W  = (DATA_WIDTH == 32) ? 8 : (DATA_WIDTH == 16) ? 5 : 11;
  localparam int unsigned MANT_W = DATA_WIDTH - 1 - EXP_W;
  localparam logic [IDX_W-1:0] FULL_CNT = IDX_W'(NUM_ELEMENTS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]      count_next;
  logic [DATA_WIDTH-1:0] max_abs_next;
  logic [IDX_W-1:0]      max_idx_next;
  logic                  max_valid, max_valid_next;
  logic                  nan_next, short_next, ovf_next, conv_next;

  logic [MAG_W-1:0] mag;
  logic             is_nan;
  logic             capture;
  logic [IDX_W-1:0] count_inc;
  logic             sign_unused;

  // Sign is irrelevant to magnitude ordering of non-NaN IEEE-754 words.
  assign mag         = grad_data[MAG_W-1:0];
  assign sign_unused = grad_data[DATA_WIDTH-1];
  assign is_nan      = (&grad_data[DATA_WIDTH-2 -: EXP_W]) && (|grad_data[MANT_W-1:0]);
  assign capture     = (state == S_COLLECT) && grad_valid && !start && (grad_count < FULL_CNT);
  assign count_inc   = grad_count + IDX_W'(1);

  // Next-state and next-value logic; start has priority over everything but reset.
  always_comb begin
    state_next     = state;
    count_next     = grad_count;
    max_abs_next   = max_abs;
    max_idx_next   = max_idx;
    max_valid_next = max_valid;
    nan_next       = nan_seen;
    short_next     = err_short;
    ovf_next       = err_overflow;
    conv_next      = converged;

    if (start) begin
      state_next     = S_COLLECT;
      count_next     = '0;
      max_abs_next   = '0;
      max_idx_next   = '0;
      max_valid_next = 1'b0;
      nan_next       = 1'b0;
      short_next     = 1'b0;
      ovf_next       = 1'b0;
      conv_next      = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state_next = S_IDLE;
        end
        S_COLLECT: begin
          if (capture) begin
            count_next = count_inc;
            if (is_nan) begin
              nan_next = 1'b1;
            end else if (!max_valid || (mag > max_abs[MAG_W-1:0])) begin
              max_abs_next   = {1'b0, mag};
              max_idx_next   = grad_count;
              max_valid_next = 1'b1;
            end
          end
          // Completion judged on values that include this cycle's capture.
          if ((count_next == FULL_CNT) || grad_flagover) begin
            state_next = S_DONE;
            if (count_next < FULL_CNT) begin
              short_next = 1'b1;
            end
            conv_next = (max_abs_next[MAG_W-1:0] < GRAD_TOL[MAG_W-1:0]) && !nan_next && !short_next;
          end
        end
        S_DONE: begin
          state_next = S_IDLE;
          if (grad_valid) begin
            ovf_next = 1'b1;
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      grad_count   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      max_abs      <= '0;
      max_idx      <= '0;
      max_valid    <= 1'b0;
      converged    <= 1'b0;
      err_short    <= 1'b0;
      err_overflow <= 1'b0;
      nan_seen     <= 1'b0;
    end else begin
      state        <= state_next;
      grad_count   <= count_next;
      busy         <= (state_next == S_COLLECT);
      done         <= (state_next == S_DONE);
      max_abs      <= max_abs_next;
      max_idx      <= max_idx_next;
      max_valid    <= max_valid_next;
      converged    <= conv_next;
      err_short    <= short_next;
      err_overflow <= ovf_next;
      nan_seen     <= nan_next;
    end
  end

  // Element storage; survives restarts so the last vector stays readable.
  always_ff @(posedge clk) begin
    if (rst) begin
      grad_vec <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_ELEMENTS; k++) begin
        if (capture && (grad_count == IDX_W'(k))) begin
          grad_vec[k] <= grad_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_grad_vector_collector.sv
// Randomized self-checking bench for grad_vector_collector.
// Expected results come from whole-pass arithmetic over the list of elements sent.
module tb_grad_vector_collector;

  localparam int unsigned N  = 50;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 6;
  localparam logic [DW-1:0] TOL = 64'h3EB0C6F7A0B5ED8D;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              grad_valid;
  logic [DW-1:0]     grad_data;
  logic              grad_flagover;
  logic [N-1:0][DW-1:0] grad_vec;
  logic [IW-1:0]     grad_count;
  logic              busy;
  logic              done;
  logic [DW-1:0]     max_abs;
  logic [IW-1:0]     max_idx;
  logic              converged;
  logic              err_short;
  logic              err_overflow;
  logic              nan_seen;

  grad_vector_collector dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .grad_valid   (grad_valid),
    .grad_data    (grad_data),
    .grad_flagover(grad_flagover),
    .grad_vec     (grad_vec),
    .grad_count   (grad_count),
    .busy         (busy),
    .done         (done),
    .max_abs      (max_abs),
    .max_idx      (max_idx),
    .converged    (converged),
    .err_short    (err_short),
    .err_overflow (err_overflow),
    .nan_seen     (nan_seen)
  );

  always #5 clk = ~clk;

  int n_vectors = 0;
  int n_miscompares = 0;

  logic [DW-1:0] exp_vec   [N];
  logic [DW-1:0] pass_data [N];
  logic          last_conv;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit elem_is_nan(input logic [DW-1:0] d);
    return (d[62:52] == 11'h7FF) && (d[51:0] != 52'd0);
  endfunction

  function automatic logic [DW-1:0] rand64();
    logic [DW-1:0] v;
    v = {$urandom(), $urandom()};
    return v;
  endfunction

  // mode 0: all magnitudes below the threshold; mode 1: mixed classes incl. NaN/inf/zero.
  function automatic logic [DW-1:0] rand_elem(input int mode);
    logic [DW-1:0] r;
    logic [51:0]   mant;
    logic [10:0]   ex;
    int            sel;
    r    = rand64();
    mant = r[51:0];
    sel  = (mode == 0) ? 3 : int'($urandom_range(0, 9));
    case (sel)
      0: begin
        if (mant == 52'd0) mant = 52'd1;
        ex = 11'h7FF;
      end
      1: begin
        mant = 52'd0;
        ex = 11'h7FF;
      end
      2: begin
        mant = 52'd0;
        ex = 11'h000;
      end
      3, 4, 5: ex = 11'(11'h3D0 + 11'($urandom_range(0, 26)));
      default: ex = 11'($urandom_range(0, 2046));
    endcase
    return {r[63], ex, mant};
  endfunction

  task automatic fill_random(input int mode);
    for (int i = 0; i < int'(N); i++) begin
      pass_data[i] = rand_elem(mode);
      if (i > 0 && $urandom_range(0, 7) == 0) begin
        pass_data[i] = pass_data[i-1] ^ {1'b1, 63'd0};
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, 64'(busy), 64'(0));
    check_val({tag, "_done"}, 64'(done), 64'(0));
    check_val({tag, "_count"}, 64'(grad_count), 64'(0));
    check_val({tag, "_max_abs"}, max_abs, 64'(0));
    check_val({tag, "_max_idx"}, 64'(max_idx), 64'(0));
    check_val({tag, "_conv"}, 64'(converged), 64'(0));
    check_val({tag, "_err_short"}, 64'(err_short), 64'(0));
    check_val({tag, "_err_ovf"}, 64'(err_overflow), 64'(0));
    check_val({tag, "_nan"}, 64'(nan_seen), 64'(0));
    for (int k = 0; k < int'(N); k++) begin
      check_val($sformatf("%s_vec[%0d]", tag, k), grad_vec[k], 64'(0));
    end
  endtask

  // Expected pass results from the list of elements that were sent.
  task automatic check_pass(input int n, input string tag);
    logic [62:0] best;
    int          bidx;
    bit          have, nan, shrt, conv;
    best = '0; bidx = 0; have = 0; nan = 0;
    for (int i = 0; i < n; i++) begin
      exp_vec[i] = pass_data[i];
      if (elem_is_nan(pass_data[i])) nan = 1;
      else if (!have || pass_data[i][62:0] > best) begin
        best = pass_data[i][62:0];
        bidx = i;
        have = 1;
      end
    end
    shrt = (n < int'(N));
    conv = !shrt && !nan && (best < TOL[62:0]);
    last_conv = conv;
    check_val({tag, "_done"}, 64'(done), 64'(1));
    check_val({tag, "_busy"}, 64'(busy), 64'(0));
    check_val({tag, "_count"}, 64'(grad_count), 64'(n));
    check_val({tag, "_max_abs"}, max_abs, {1'b0, best});
    check_val({tag, "_max_idx"}, 64'(max_idx), 64'(bidx));
    check_val({tag, "_conv"}, 64'(converged), 64'(conv));
    check_val({tag, "_err_short"}, 64'(err_short), 64'(shrt));
    check_val({tag, "_err_ovf"}, 64'(err_overflow), 64'(0));
    check_val({tag, "_nan"}, 64'(nan_seen), 64'(nan));
    for (int k = 0; k < int'(N); k++) begin
      check_val($sformatf("%s_vec[%0d]", tag, k), grad_vec[k], exp_vec[k]);
    end
  endtask

  // extra: 0 idle after done, 1 valid during the done cycle, 2 flagover during the done cycle.
  task automatic do_pass(input int n, input bit flag_last, input int extra, input string tag);
    bit early;
    early = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check_val({tag, "_start_busy"}, 64'(busy), 64'(1));
    check_val({tag, "_start_count"}, 64'(grad_count), 64'(0));
    check_val({tag, "_start_errs"}, 64'({err_short, err_overflow, nan_seen, converged}), 64'(0));
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        step();
        if (done) early = 1;
      end
      grad_valid    = 1'b1;
      grad_data     = pass_data[i];
      grad_flagover = flag_last && (i == n - 1);
      step();
      grad_valid    = 1'b0;
      grad_flagover = 1'b0;
      grad_data     = rand64();
      if (i != n - 1 && done) early = 1;
    end
    if (n < int'(N) && !flag_last) begin
      step();
      if (done) early = 1;
      grad_flagover = 1'b1;
      step();
      grad_flagover = 1'b0;
    end
    check_val({tag, "_early_done"}, 64'(early), 64'(0));
    check_pass(n, tag);
    if (extra == 1) begin
      grad_valid = 1'b1;
      grad_data  = rand64();
      step();
      grad_valid = 1'b0;
      check_val({tag, "_ovf_flag"}, 64'(err_overflow), 64'(1));
      check_val({tag, "_ovf_count"}, 64'(grad_count), 64'(n));
      check_val({tag, "_ovf_done"}, 64'(done), 64'(0));
    end else if (extra == 2) begin
      grad_flagover = 1'b1;
      step();
      grad_flagover = 1'b0;
      check_val({tag, "_late_flag_short"}, 64'(err_short), 64'(n < int'(N)));
      check_val({tag, "_late_flag_done"}, 64'(done), 64'(0));
    end else begin
      step();
      check_val({tag, "_pulse_end"}, 64'(done), 64'(0));
    end
    check_val({tag, "_conv_hold"}, 64'(converged), 64'(last_conv));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; grad_valid = 1'b0; grad_data = '0; grad_flagover = 1'b0;
    for (int k = 0; k < int'(N); k++) exp_vec[k] = '0;
    step();
    step();
    rst = 1'b0;
    check_all_zero("reset");

    // Ramp 0.0 .. 49.0, late flagover ignored.
    for (int k = 0; k < int'(N); k++) pass_data[k] = $realtobits(real'(k));
    do_pass(N, 1'b0, 2, "ramp");
    check_val("ramp_vec7_const", grad_vec[7], 64'h401C000000000000);
    check_val("ramp_idx_const", 64'(max_idx), 64'(49));

    // Valids while idle are ignored.
    repeat (3) begin
      grad_valid = 1'b1; grad_data = rand64();
      step();
    end
    grad_valid = 1'b0;
    check_val("idle_valid_count", 64'(grad_count), 64'(N));
    check_val("idle_valid_ovf", 64'(err_overflow), 64'(0));
    check_val("idle_valid_vec0", grad_vec[0], exp_vec[0]);

    // Small values with one larger negative element.
    for (int k = 0; k < int'(N); k++) pass_data[k] = 64'h3E7AD7F29ABCAF48;
    pass_data[12] = 64'hBE9A36E2EB1C432D;
    do_pass(N, 1'b0, 0, "small");
    check_val("small_max_const", max_abs, 64'h3E9A36E2EB1C432D);
    check_val("small_conv_const", 64'(converged), 64'(1));

    // Short pass, then flagover coincident with the last valid.
    fill_random(1);
    do_pass(30, 1'b0, 0, "short30");
    fill_random(0);
    do_pass(N, 1'b1, 0, "flag_last");

    // NaN element plus a valid during the done cycle.
    for (int k = 0; k < int'(N); k++) pass_data[k] = 64'h3E7AD7F29ABCAF48;
    pass_data[5] = 64'h7FF8000000000000;
    do_pass(N, 1'b0, 1, "nan");
    check_val("nan_idx_not5", 64'(max_idx == 6'd5), 64'(0));

    // Restart mid-pass.
    fill_random(1);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      grad_valid = 1'b1; grad_data = pass_data[i];
      step();
      exp_vec[i] = pass_data[i];
    end
    grad_valid = 1'b0;
    check_val("partial_count", 64'(grad_count), 64'(20));
    check_val("partial_done", 64'(done), 64'(0));
    fill_random(0);
    do_pass(N, 1'b0, 0, "restart");

    // Empty pass.
    do_pass(0, 1'b0, 0, "empty");

    // Reset in the middle of a pass.
    fill_random(1);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      grad_valid = 1'b1; grad_data = pass_data[i];
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0; grad_valid = 1'b0;
    for (int k = 0; k < int'(N); k++) exp_vec[k] = '0;
    check_all_zero("midrst");
    repeat (3) begin
      step();
      check_val("midrst_no_done", 64'(done), 64'(0));
    end

    // Randomized passes.
    for (int p = 0; p < 20; p++) begin
      int n;
      fill_random(int'($urandom_range(0, 1)));
      n = int'($urandom_range(1, N));
      do_pass(n, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), $sformatf("rnd%0d", p));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
